// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl : machine-mode interrupt controller for the three-stage RISC-V core.
//
// Each rising edge on irq is captured into a pending bit. The pending bits are
// masked by irq_en and gie, and the lowest index wins. The winner is frozen
// while the controller waits for a cycle with no stall and no flush. It then
// issues a one-cycle intr_exc/irq_ack pulse and stays in service until
// is_mret retires.
//
// Optional feature macro: INTR_TIMER_EN
//   When it is defined, the block has a free-running 32-bit mtime counter and
//   an mtimecmp register. Their level compare is the lowest-priority source.
//   That source reports mcause 0x80000007 and irq_id 0xF.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   irq        in   [NUM_SRC] raw level interrupt requests
//   irq_en     in   [NUM_SRC] per-source enable (mie image)
//   gie        in   global interrupt enable (mstatus.MIE)
//   stall      in   pipeline stall
//   flush      in   pipeline flush
//   is_mret    in   mret retiring in MEM/WB
//   tmr_cmp    in   [32] new mtimecmp value      (INTR_TIMER_EN only)
//   tmr_cmp_we in   mtimecmp write strobe        (INTR_TIMER_EN only)
//   intr_exc   out  one-cycle interrupt-take pulse to the CSR unit
//   mcause     out  [32] cause of the taken interrupt
//   irq_id     out  [4] index of the in-service source
//   irq_ack    out  [NUM_SRC] one-hot one-cycle acknowledge
//   busy       out  controller in ARB, TAKE or SERVICE
// -----------------------------------------------------------------------------
module intr_ctrl #(
   parameter int NUM_SRC    = 4,
   parameter int CAUSE_BASE = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq,
   input  logic [NUM_SRC-1:0] irq_en,
   input  logic               gie,
   input  logic               stall,
   input  logic               flush,
   input  logic               is_mret,
`ifdef INTR_TIMER_EN
   input  logic [31:0]        tmr_cmp,
   input  logic               tmr_cmp_we,
`endif
   output logic               intr_exc,
   output logic [31:0]        mcause,
   output logic [3:0]         irq_id,
   output logic [NUM_SRC-1:0] irq_ack,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_TAKE, S_SERVICE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [NUM_SRC-1:0] r_irq_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic               r_is_timer;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_id_onehot;
   logic [3:0]         w_win_id;
   logic               w_timer_lvl;
   logic               w_keep;
   logic [3:0]         w_nxt_id;
   logic [31:0]        w_nxt_cause;
   logic               w_nxt_tmr;

   // Returns the lowest set index of the vector, which is the highest priority.
   function automatic logic [3:0] f_prio(input logic [NUM_SRC-1:0] v);
      logic [3:0] id;
      id = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            id = i[3:0];
         end
      end
      return id;
   endfunction

   assign w_edge      = irq & ~r_irq_prev;
   assign w_elig      = r_pending & irq_en & {NUM_SRC{gie}};
   assign w_win_id    = f_prio(w_elig);
   assign w_id_onehot = NUM_SRC'(1'b1) << irq_id;

`ifdef INTR_TIMER_EN
   logic [31:0] r_mtime;
   logic [31:0] r_mtimecmp;

   // Free-running mtime and the software-written compare register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mtime    <= 32'd0;
         r_mtimecmp <= 32'hFFFF_FFFF;
      end else begin
         r_mtime <= r_mtime + 32'd1;
         if (tmr_cmp_we) begin
            r_mtimecmp <= tmr_cmp;
         end else begin
            r_mtimecmp <= r_mtimecmp;
         end
      end
   end

   assign w_timer_lvl = (r_mtime >= r_mtimecmp);
`else
   assign w_timer_lvl = 1'b0;
`endif

   // Edge capture. A new edge beats an ack for the same bit in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_prev <= '0;
         r_pending  <= '0;
      end else begin
         r_irq_prev <= irq;
         r_pending  <= (r_pending & ~irq_ack) | w_edge;
      end
   end

   // The winner must still be enabled while the controller waits in ARB.
   assign w_keep = r_is_timer ? w_timer_lvl : |(irq_en & w_id_onehot);

   // Next-state logic and the values latched with the winner.
   always_comb begin
      w_next      = r_state;
      w_nxt_id    = irq_id;
      w_nxt_cause = mcause;
      w_nxt_tmr   = r_is_timer;
      case (r_state)
         S_IDLE: begin
            if (gie && ((|w_elig) || w_timer_lvl)) begin
               w_next = S_ARB;
               if (|w_elig) begin
                  w_nxt_id    = w_win_id;
                  w_nxt_cause = 32'h8000_0000 | (32'(CAUSE_BASE) + {28'd0, w_win_id});
                  w_nxt_tmr   = 1'b0;
               end else begin
                  w_nxt_id    = 4'hF;
                  w_nxt_cause = 32'h8000_0007;
                  w_nxt_tmr   = 1'b1;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ARB: begin
            if (!gie || !w_keep) begin
               w_next = S_IDLE;
            end else if (!stall && !flush) begin
               w_next = S_TAKE;
            end else begin
               w_next = S_ARB;
            end
         end
         S_TAKE: begin
            w_next = S_SERVICE;
         end
         S_SERVICE: begin
            if (is_mret) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_SERVICE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register and registered outputs. The outputs are computed from
   // w_next so that the pulses line up with the TAKE state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_is_timer <= 1'b0;
         irq_id     <= 4'd0;
         mcause     <= 32'd0;
         intr_exc   <= 1'b0;
         irq_ack    <= '0;
         busy       <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_is_timer <= w_nxt_tmr;
         irq_id     <= w_nxt_id;
         mcause     <= w_nxt_cause;
         intr_exc   <= (w_next == S_TAKE);
         irq_ack    <= ((w_next == S_TAKE) && !w_nxt_tmr) ? w_id_onehot : '0;
         busy       <= (w_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq;
   logic [3:0]  irq_en;
   logic        gie;
   logic        stall;
   logic        flush;
   logic        is_mret;
   logic        intr_exc;
   logic [31:0] mcause;
   logic [3:0]  irq_id;
   logic [3:0]  irq_ack;
   logic        busy;
`ifdef INTR_TIMER_EN
   logic [31:0] tmr_cmp;
   logic        tmr_cmp_we;
   int          mt;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] cause;
      logic [3:0]  ack;
      logic [3:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_chk   = 0;
   int   n_err   = 0;

   intr_ctrl #(.NUM_SRC(4), .CAUSE_BASE(16)) dut (
      .clk(clk), .reset(reset), .irq(irq), .irq_en(irq_en), .gie(gie),
      .stall(stall), .flush(flush), .is_mret(is_mret),
`ifdef INTR_TIMER_EN
      .tmr_cmp(tmr_cmp), .tmr_cmp_we(tmr_cmp_we),
`endif
      .intr_exc(intr_exc), .mcause(mcause), .irq_id(irq_id),
      .irq_ack(irq_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

`ifdef INTR_TIMER_EN
   always @(posedge clk or posedge reset) begin
      if (reset) mt <= 0;
      else       mt <= mt + 1;
   end
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_take(input int c, input logic [31:0] cause,
                              input logic [3:0] ack, input logic [3:0] id);
      exp_t e;
      e.cyc = c; e.cause = cause; e.ack = ack; e.id = id;
      exp_q.push_back(e);
   endtask

   task automatic mret_pulse();
      is_mret = 1'b1;
      tick(1);
      is_mret = 1'b0;
   endtask

   // Scoreboard: every intr_exc pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (intr_exc) begin
            if (exp_q.size() == 0) begin
               chk("spurious_exc", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("exc_cycle", cyc, e.cyc);
               chk("mcause", mcause, e.cause);
               chk("irq_ack", {28'd0, irq_ack}, {28'd0, e.ack});
               chk("irq_id", {28'd0, irq_id}, {28'd0, e.id});
            end
         end else if (irq_ack != 4'd0) begin
            chk("stray_ack", {28'd0, irq_ack}, 32'd0);
         end
      end
   end

   task automatic stall_case(input bit use_flush);
      irq = 4'b0100;
      if (use_flush) flush = 1'b1; else stall = 1'b1;
      tick(7);
      chk(use_flush ? "flush_busy" : "stall_busy", {31'd0, busy}, 32'd1);
      expect_take(cyc + 1, 32'h8000_0012, 4'b0100, 4'd2);
      stall = 1'b0;
      flush = 1'b0;
      tick(3);
      mret_pulse();
      irq = 4'b0000;
      tick(2);
   endtask

   initial begin
      reset = 1'b1; irq = 4'b0; irq_en = 4'hF; gie = 1'b1;
      stall = 1'b0; flush = 1'b0; is_mret = 1'b0;
`ifdef INTR_TIMER_EN
      tmr_cmp = 32'd0; tmr_cmp_we = 1'b0;
`endif
      tick(2);
      chk("rst_exc", {31'd0, intr_exc}, 32'd0);
      chk("rst_mcause", mcause, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick(2);

      // Single source, three-edge latency.
      irq = 4'b0010;
      expect_take(cyc + 3, 32'h8000_0011, 4'b0010, 4'd1);
      tick(5);
      chk("svc_busy", {31'd0, busy}, 32'd1);
      mret_pulse();
      chk("mret_idle", {31'd0, busy}, 32'd0);
      irq = 4'b0000;
      tick(2);

      // Simultaneous edges: source 0 first, source 3 three cycles after mret.
      irq = 4'b1001;
      expect_take(cyc + 3, 32'h8000_0010, 4'b0001, 4'd0);
      tick(6);
      expect_take(cyc + 3, 32'h8000_0013, 4'b1000, 4'd3);
      mret_pulse();
      tick(5);
      mret_pulse();
      irq = 4'b0000;
      tick(2);

      stall_case(1'b0);
      stall_case(1'b1);

      // gie drops in ARB: back to IDLE, pending kept, taken when gie returns.
      irq = 4'b0001;
      tick(2);
      chk("arb_busy", {31'd0, busy}, 32'd1);
      gie = 1'b0;
      tick(1);
      chk("gie_drop_idle", {31'd0, busy}, 32'd0);
      tick(3);
      chk("gie_off_idle", {31'd0, busy}, 32'd0);
      gie = 1'b1;
      expect_take(cyc + 2, 32'h8000_0010, 4'b0001, 4'd0);
      tick(4);
      mret_pulse();
      irq = 4'b0000;
      tick(2);

      // Reset in SERVICE: outputs clear immediately, no take without a new edge.
      irq = 4'b0100;
      expect_take(cyc + 3, 32'h8000_0012, 4'b0100, 4'd2);
      tick(5);
      chk("pre_rst_id", {28'd0, irq_id}, 32'd2);
      reset = 1'b1;
      irq = 4'b0000;
      #1;
      chk("rst_exc2", {31'd0, intr_exc}, 32'd0);
      chk("rst_mcause2", mcause, 32'd0);
      chk("rst_id2", {28'd0, irq_id}, 32'd0);
      chk("rst_ack2", {28'd0, irq_ack}, 32'd0);
      chk("rst_busy2", {31'd0, busy}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(6);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
      irq = 4'b0100;
      expect_take(cyc + 3, 32'h8000_0012, 4'b0100, 4'd2);
      tick(5);
      mret_pulse();
      irq = 4'b0000;
      tick(2);

`ifdef INTR_TIMER_EN
      // Timer: compare written at mtime=10, take when mtime reaches 22.
      while (mt != 10) tick(1);
      tmr_cmp = 32'd20; tmr_cmp_we = 1'b1;
      expect_take(cyc + 12, 32'h8000_0007, 4'b0000, 4'hF);
      tick(1);
      tmr_cmp_we = 1'b0;
      tick(14);
      tmr_cmp = 32'hFFFF_FFFF; tmr_cmp_we = 1'b1;
      tick(1);
      tmr_cmp_we = 1'b0;
      mret_pulse();
      tick(8);
      chk("tmr_no_retake", {31'd0, busy}, 32'd0);
`endif

      tick(4);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Machine-mode interrupt controller for the three-stage RISC-V pipeline.
- Latches NUM_SRC external interrupt requests and masks them with per-source enables and the global enable.
- Arbitrates by fixed priority and waits for a safe pipeline slot (no stall, no flush).
- Drives the single-cycle intr_exc pulse into the datapath CSR unit, then holds off further interrupts until is_mret retires.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..16).
- CAUSE_BASE, 16, mcause code for source 0; source k reports CAUSE_BASE+k.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq  input  NUM_SRC  raw interrupt request lines, level, synchronous to clk.
- irq_en  input  NUM_SRC  per-source enable (mie image).
- gie  input  1  global interrupt enable (mstatus.MIE).
- stall  input  1  pipeline stall from the forwarding unit.
- flush  input  1  pipeline flush (branch taken).
- is_mret  input  1  mret in the memory/writeback stage.
- intr_exc  output  1  one-cycle pulse to the CSR unit; datapath vectors to mtvec.
- mcause  output  32  cause for the taken interrupt: bit31=1, low bits CAUSE_BASE+id.
- irq_id  output  4  index of the in-service source.
- irq_ack  output  NUM_SRC  one-hot one-cycle acknowledge to the source.
- busy  output  1  high while in ARB, TAKE or SERVICE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, pending=0, irq_prev=0.
  - All outputs 0 (intr_exc, mcause, irq_id, irq_ack, busy).
- Edge capture:
  - irq_prev registers irq each cycle.
  - Rising edge (irq & ~irq_prev) sets the pending bit.
  - A pending bit clears only on that source's irq_ack.
  - An edge and an ack for the same bit in the same cycle leave the bit set (set wins).
- Eligible set: pending & irq_en, qualified by gie. Lowest index has highest priority.
- FSM:
  - IDLE: if gie and eligible != 0, go to ARB next cycle; latch winner into irq_id and mcause.
  - ARB:
    - If gie drops or the winner's irq_en drops, return to IDLE; pending is unchanged and irq_id holds its old value.
    - Else if stall=0 and flush=0, go to TAKE.
    - Else stay in ARB. The winner is frozen; a higher-priority arrival does not preempt.
  - TAKE (exactly 1 cycle):
    - intr_exc=1; irq_ack[irq_id]=1; pending[irq_id] clears at the next edge.
    - Go to SERVICE.
  - SERVICE:
    - No new arbitration; new edges still latch into pending.
    - On is_mret=1, go to IDLE. Earliest re-take is 3 cycles after is_mret (IDLE, ARB, TAKE).
- Latency: from an irq rising edge (gie=1, enabled, no stall), intr_exc asserts on the 3rd rising clk edge after irq is sampled high (capture, IDLE->ARB, ARB->TAKE).
- is_mret outside SERVICE is ignored.
- stall/flush in TAKE have no effect; the pulse is never stretched.
- mcause and irq_id hold their value from ARB through SERVICE, and until the next ARB.
- busy = (state != IDLE).
- NUM_SRC < 16: unused irq_id upper bits are 0.

Optional Feature:
- Macro: INTR_TIMER_EN.
- Defined:
  - Adds ports tmr_cmp (input, 32) and tmr_cmp_we (input, 1).
  - Adds an internal 32-bit mtime that increments every clk and wraps 0xFFFFFFFF->0.
  - mtimecmp register, reset 0xFFFFFFFF, written from tmr_cmp when tmr_cmp_we=1.
  - Timer source is level (mtime >= mtimecmp) and is lowest priority, below all irq bits.
  - Timer mcause = 0x80000007, irq_id = 0xF.
  - The timer is not edge-captured and has no ack; software clears it by rewriting mtimecmp.
  - gie still gates the timer.
- Undefined: the timer ports, mtime and mtimecmp are absent; behaviour is exactly as above.

Test Plan:
- Reset mid-SERVICE (irq_id=2): assert reset -> all outputs 0 immediately; pending=0 after release; no intr_exc until a new edge.
- irq[1] rises, irq_en=4'b1111, gie=1, stall=0 -> intr_exc=1 on the 3rd edge after irq is sampled high; mcause=0x80000011; irq_ack=4'b0010; busy=1 until is_mret.
- irq[3] and irq[0] rise in the same cycle -> source 0 taken first (mcause=0x80000010). After is_mret, source 3 taken (mcause=0x80000013) 3 cycles later.
- irq[2] pending, stall=1 for 5 cycles in ARB -> intr_exc stays 0 throughout; it pulses the cycle after stall falls. Repeat with flush=1 -> same.
- irq[0] pending in ARB, gie drops -> return to IDLE, no intr_exc, pending[0] kept. Raise gie -> taken with mcause=0x80000010.
- INTR_TIMER_EN defined: write tmr_cmp=20 at mtime=10 -> intr_exc when mtime reaches 20 plus 2 cycles; mcause=0x80000007. Rewrite tmr_cmp=0xFFFFFFFF before is_mret -> no re-take.
